// File: rtl/hemaia_clock_divisor_sequencer.sv
// hemaia_clock_divisor_sequencer
//
// Upstream control stage for the hemaia clock divider, clocked by the
// undivided source clock. Accepts a target divisor over a valid/ready
// handshake and walks the divider's divisor towards it one step at a time,
// waiting a settle window after every step so the divided clock never sees
// a large frequency jump. A target of 0 gates the divided clock; leaving
// the gated state first re-issues the last nonzero divisor.
//
// Ports:
//   clk_i            source clock (same clock as the divider)
//   rst_i            synchronous, active-high reset
//   target_i         requested divisor, 0 requests clock gating
//   target_valid_i   request valid
//   target_ready_o   request can be accepted (sequencer idle)
//   divisor_o        to divider divisor_i, held stable between steps
//   divisor_valid_o  to divider divisor_valid_i, one-cycle pulse per step
//   current_o        last nonzero divisor issued
//   gated_o          last issued value was 0
//   busy_o           a sequence is in progress
//   done_o           one-cycle pulse when a sequence completes
//
// Optional build macro HEMAIA_CLK_SEQ_STEP_COUNT_EN adds:
//   step_count_o     16-bit saturating count of divisor_valid_o pulses
//   step_count_clr_i synchronous clear of step_count_o (wins over increment)

module hemaia_clock_divisor_sequencer #(
   parameter int unsigned MaxDivisionWidth = 4,
   parameter int unsigned DefaultDivision  = 1,
   parameter int unsigned SettleCycles     = 32
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [MaxDivisionWidth-1:0] target_i,
   input  logic                        target_valid_i,
   output logic                        target_ready_o,
   output logic [MaxDivisionWidth-1:0] divisor_o,
   output logic                        divisor_valid_o,
   output logic [MaxDivisionWidth-1:0] current_o,
   output logic                        gated_o,
   output logic                        busy_o,
`ifdef HEMAIA_CLK_SEQ_STEP_COUNT_EN
   output logic                        done_o,
   output logic [15:0]                 step_count_o,
   input  logic                        step_count_clr_i
`else
   output logic                        done_o
`endif
);

   localparam int unsigned CntW = (SettleCycles > 2) ? $clog2(SettleCycles) : 1;
   localparam logic [CntW-1:0] SettleLoad = CntW'(SettleCycles - 1);
   localparam logic [MaxDivisionWidth-1:0] DivOne = MaxDivisionWidth'(1);
   localparam logic [MaxDivisionWidth-1:0] DivReset = MaxDivisionWidth'(DefaultDivision);

   // The settle window must outlast one full divider period plus its
   // sampling latency, otherwise a step could land mid-period.
   if (SettleCycles < (2 ** MaxDivisionWidth) + 2) begin : g_settle_check
      $error("SettleCycles must be at least 2**MaxDivisionWidth + 2");
   end

   typedef enum logic [2:0] {
      IDLE,
      GATE,
      UNGATE,
      STEP,
      SETTLE,
      FINISH
   } state_e;

   state_e                      state_q, state_d;
   logic [MaxDivisionWidth-1:0] target_q, target_d;
   logic [CntW-1:0]             cnt_q, cnt_d;
   logic [MaxDivisionWidth-1:0] divisor_q, divisor_d;
   logic [MaxDivisionWidth-1:0] current_q, current_d;
   logic                        valid_q, valid_d;
   logic                        gated_q, gated_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        ready_q, ready_d;
   logic [MaxDivisionWidth-1:0] step_val;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         target_q  <= '0;
         cnt_q     <= '0;
         divisor_q <= DivReset;
         current_q <= DivReset;
         valid_q   <= 1'b0;
         gated_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         cnt_q     <= cnt_d;
         divisor_q <= divisor_d;
         current_q <= current_d;
         valid_q   <= valid_d;
         gated_q   <= gated_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      cnt_d     = cnt_q;
      divisor_d = divisor_q;
      current_d = current_q;
      valid_d   = 1'b0;
      gated_d   = gated_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      // Steps move towards target_q, so this never wraps past 0 or the max.
      step_val  = (target_q > current_q) ? current_q + DivOne : current_q - DivOne;

      unique case (state_q)
         IDLE: begin
            if (target_valid_i) begin
               target_d = target_i;
               busy_d   = 1'b1;
               if ((target_i == '0 && gated_q) ||
                   (target_i != '0 && !gated_q && target_i == current_q)) begin
                  state_d = FINISH;
               end else if (target_i == '0) begin
                  state_d = GATE;
               end else if (gated_q) begin
                  state_d = UNGATE;
               end else begin
                  state_d = STEP;
               end
            end
         end
         GATE: begin
            divisor_d = '0;
            valid_d   = 1'b1;
            gated_d   = 1'b1;
            cnt_d     = SettleLoad;
            state_d   = SETTLE;
         end
         UNGATE: begin
            divisor_d = current_q;
            valid_d   = 1'b1;
            gated_d   = 1'b0;
            cnt_d     = SettleLoad;
            state_d   = SETTLE;
         end
         STEP: begin
            divisor_d = step_val;
            current_d = step_val;
            valid_d   = 1'b1;
            cnt_d     = SettleLoad;
            state_d   = SETTLE;
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               if ((gated_q && target_q == '0) || current_q == target_q) begin
                  state_d = FINISH;
               end else begin
                  state_d = STEP;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Registered ready tracks the state it will be in next cycle.
      ready_d = (state_d == IDLE);
   end

   assign target_ready_o  = ready_q;
   assign divisor_o       = divisor_q;
   assign divisor_valid_o = valid_q;
   assign current_o       = current_q;
   assign gated_o         = gated_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;

`ifdef HEMAIA_CLK_SEQ_STEP_COUNT_EN
   logic [15:0] step_count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         step_count_q <= '0;
      end else if (step_count_clr_i) begin
         step_count_q <= '0;
      end else if (valid_q && step_count_q != '1) begin
         step_count_q <= step_count_q + 16'd1;
      end
   end

   assign step_count_o = step_count_q;
`endif

endmodule

// File: tb/tb_hemaia_clock_divisor_sequencer.sv
// Self-checking bench for hemaia_clock_divisor_sequencer (default build).
// A reference model expands every accepted request into the list of
// expected divisor pulses and the done pulse, each with its cycle number;
// a monitor pops and compares them as the DUT presents them.

module tb_hemaia_clock_divisor_sequencer;

   localparam int unsigned W = 4;
   localparam int unsigned S = 20;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic [W-1:0] target_i = '0;
   logic         target_valid_i = 1'b0;
   logic         target_ready_o;
   logic [W-1:0] divisor_o;
   logic         divisor_valid_o;
   logic [W-1:0] current_o;
   logic         gated_o;
   logic         busy_o;
   logic         done_o;

   hemaia_clock_divisor_sequencer #(
      .MaxDivisionWidth(W),
      .DefaultDivision (1),
      .SettleCycles    (S)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .target_i       (target_i),
      .target_valid_i (target_valid_i),
      .target_ready_o (target_ready_o),
      .divisor_o      (divisor_o),
      .divisor_valid_o(divisor_valid_o),
      .current_o      (current_o),
      .gated_o        (gated_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      int       at;
      bit       is_done;
      int       val;
      bit       gated;
      int       cur;
   } evt_t;

   evt_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;

   // Model state: divisor level and gating after all accepted requests.
   int   m_cur = 1;
   bit   m_gated = 0;
   int   m_ready_cyc = 0;

   function automatic void chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endfunction

   function automatic void push(input int at, input bit d, input int v);
      evt_t e;
      e.at = at; e.is_done = d; e.val = v; e.gated = m_gated; e.cur = m_cur;
      sb.push_back(e);
   endfunction

   // a = cycle count after the accepting edge.
   function automatic void model_accept(input int a, input int t);
      int c = a + 1;
      if ((t == 0 && m_gated) || (t != 0 && !m_gated && t == m_cur)) begin
         push(c, 1, 0);
      end else if (t == 0) begin
         m_gated = 1;
         push(c, 0, 0);
         c += S + 1;
         push(c, 1, 0);
      end else begin
         if (m_gated) begin
            m_gated = 0;
            push(c, 0, m_cur);
            c += S + 1;
         end
         while (m_cur != t) begin
            m_cur = (t > m_cur) ? m_cur + 1 : m_cur - 1;
            push(c, 0, m_cur);
            c += S + 1;
         end
         push(c, 1, 0);
      end
      m_ready_cyc = c;
   endfunction

   // Monitor.
   always @(negedge clk_i) begin
      if (!rst_i && (divisor_valid_o || done_o)) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL spurious_event: valid=%0d done=%0d divisor=%0d with nothing expected (cycle %0d)",
                     divisor_valid_o, done_o, divisor_o, cyc);
         end else begin
            evt_t e;
            e = sb.pop_front();
            chk("event_kind_is_done", int'(done_o), int'(e.is_done));
            chk("event_cycle", cyc, e.at);
            chk("gated_o", int'(gated_o), int'(e.gated));
            chk("current_o", int'(current_o), e.cur);
            if (e.is_done) begin
               chk("busy_at_done", int'(busy_o), 0);
               chk("ready_at_done", int'(target_ready_o), 1);
            end else begin
               chk("divisor_o", int'(divisor_o), e.val);
               chk("busy_at_pulse", int'(busy_o), 1);
            end
         end
      end
   end

   task automatic check_reset_state();
      chk("rst_divisor", int'(divisor_o), 1);
      chk("rst_current", int'(current_o), 1);
      chk("rst_ready", int'(target_ready_o), 1);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_gated", int'(gated_o), 0);
      chk("rst_valid", int'(divisor_valid_o), 0);
      chk("rst_done", int'(done_o), 0);
   endtask

   task automatic request(input int t);
      bit acc = 0;
      int n = 0;
      @(negedge clk_i);
      target_i = W'(t);
      target_valid_i = 1'b1;
      while (!acc && n < 1000) begin
         chk("target_ready_o", int'(target_ready_o), int'(cyc >= m_ready_cyc));
         if (target_ready_o) begin
            acc = 1;
            model_accept(cyc + 1, t);
         end
         @(negedge clk_i);
         n++;
      end
      target_valid_i = 1'b0;
      if (!acc) begin
         n_total++;
         $display("FAIL accept_timeout: target %0d not accepted in %0d cycles", t, n);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk_i);
         n++;
      end
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL idle_timeout: %0d expected events still pending", sb.size());
         sb.delete();
      end
      repeat (3) @(negedge clk_i);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      sb.delete();
      m_cur = 1;
      m_gated = 0;
      m_ready_cyc = 0;
      check_reset_state();
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      check_reset_state();
      repeat (5) @(negedge clk_i);
      chk("no_pulse_after_reset", int'(divisor_valid_o), 0);

      // Ramp up, then request while busy (held until idle) to step down.
      request(4);
      request(2);
      wait_idle();

      // Gate, then ungate towards 3.
      request(0);
      wait_idle();
      request(3);
      wait_idle();

      // No-op requests: equal target, and gating while already gated.
      request(2);
      wait_idle();
      request(2);
      wait_idle();
      request(0);
      wait_idle();
      request(0);
      wait_idle();

      // Randomized targets with random idle gaps.
      for (int i = 0; i < 12; i++) begin
         request(int'($urandom_range(0, 15)));
         if ($urandom_range(0, 1) == 1) wait_idle();
         repeat ($urandom_range(0, 4)) @(negedge clk_i);
      end
      wait_idle();
      request(15);
      request(1);
      wait_idle();

      // Reset in the middle of a settle window.
      do_reset();
      request(8);
      repeat (10) @(negedge clk_i);
      chk("busy_mid_settle", int'(busy_o), 1);
      do_reset();
      repeat (S + 5) @(negedge clk_i);
      chk("no_pulse_after_mid_reset", int'(divisor_valid_o), 0);
      request(3);
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
